// File: rtl/gpio_input_ctl.sv
// Player-2 left/right input conditioning: 2-FF sync, per-pin debounce and
// first-pressed-wins direction arbitration with registered press pulses.
//
// state    | meaning
// ---------+-----------------------------------------------
// ST_NONE  | no direction owned (both released or both held)
// ST_LEFT  | left pin owns the direction
// ST_RIGHT | right pin owns the direction
module gpio_input_ctl #(
    parameter int DEBOUNCE_CYCLES = 65_000,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic clk,
    input  logic rst,
    input  logic gpio_left_raw,
    input  logic gpio_right_raw,
    output logic gpio_left,
    output logic gpio_right,
    output logic gpio_left_press,
    output logic gpio_right_press
);

    localparam logic [1:0] ST_NONE  = 2'b00;
    localparam logic [1:0] ST_LEFT  = 2'b01;
    localparam logic [1:0] ST_RIGHT = 2'b10;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    // Channel index 0 is left, 1 is right.
    logic [1:0]       raw;
    logic [1:0]       sync1_q;
    logic [1:0]       sync2_q;
    logic [1:0]       db_q;
    logic [1:0]       db_d;
    logic [CNT_W-1:0] cnt_q [2];
    logic [CNT_W-1:0] cnt_d [2];

    logic [1:0]       state_q;
    logic [1:0]       state_d;
    logic             left_press_q;
    logic             right_press_q;
    logic             left_press_d;
    logic             right_press_d;

    assign raw = {gpio_right_raw, gpio_left_raw};

    // A level is accepted only after CNT_MAX+1 consecutive differing samples;
    // any sample matching the stable level restarts the count.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            db_d[i]  = db_q[i];
            cnt_d[i] = '0;
            if (sync2_q[i] != db_q[i]) begin
                if (cnt_q[i] == CNT_MAX) begin
                    db_d[i] = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_d = ST_NONE;
        case (state_q)
            ST_NONE: begin
                if (db_q[0] && !db_q[1]) begin
                    state_d = ST_LEFT;
                end else if (db_q[1] && !db_q[0]) begin
                    state_d = ST_RIGHT;
                end else begin
                    state_d = ST_NONE;
                end
            end
            ST_LEFT: begin
                if (!db_q[0]) begin
                    state_d = db_q[1] ? ST_RIGHT : ST_NONE;
                end else begin
                    state_d = ST_LEFT;
                end
            end
            ST_RIGHT: begin
                if (!db_q[1]) begin
                    state_d = db_q[0] ? ST_LEFT : ST_NONE;
                end else begin
                    state_d = ST_RIGHT;
                end
            end
            default: state_d = ST_NONE;
        endcase
    end

    assign left_press_d  = (state_d == ST_LEFT)  && (state_q != ST_LEFT);
    assign right_press_d = (state_d == ST_RIGHT) && (state_q != ST_RIGHT);

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q       <= '0;
            sync2_q       <= '0;
            db_q          <= '0;
            cnt_q[0]      <= '0;
            cnt_q[1]      <= '0;
            state_q       <= ST_NONE;
            left_press_q  <= 1'b0;
            right_press_q <= 1'b0;
        end else begin
            sync1_q       <= raw;
            sync2_q       <= sync1_q;
            db_q          <= db_d;
            cnt_q[0]      <= cnt_d[0];
            cnt_q[1]      <= cnt_d[1];
            state_q       <= state_d;
            left_press_q  <= left_press_d;
            right_press_q <= right_press_d;
        end
    end

    assign gpio_left        = (state_q == ST_LEFT);
    assign gpio_right       = (state_q == ST_RIGHT);
    assign gpio_left_press  = left_press_q;
    assign gpio_right_press = right_press_q;

endmodule

// File: tb/tb_gpio_input_ctl.sv
// Scoreboard bench for gpio_input_ctl: directed test-plan sequences plus
// random pin activity, checked every cycle against a window-based model.
module tb_gpio_input_ctl;

    localparam int D = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic pin_l = 1'b1;
    logic pin_r = 1'b1;
    logic out_l, out_r, press_l, press_r;

    int n_tests = 0;
    int n_fail  = 0;

    gpio_input_ctl #(.DEBOUNCE_CYCLES(D)) dut (
        .clk              (clk),
        .rst              (rst),
        .gpio_left_raw    (pin_l),
        .gpio_right_raw   (pin_r),
        .gpio_left        (out_l),
        .gpio_right       (out_r),
        .gpio_left_press  (press_l),
        .gpio_right_press (press_r)
    );

    always #5 clk = ~clk;

    // Expected {left, right, left_press, right_press} after each modelled edge.
    logic [3:0] exp_q [$];

    // Reference model: pins reach the debouncer two edges late; a level is
    // accepted once the last D samples seen all disagree with the stable level.
    bit raw_l [$];
    bit raw_r [$];
    bit seen_l [$];
    bit seen_r [$];
    bit m_db_l, m_db_r;
    int owner;  // 0 none, 1 left, 2 right

    function automatic bit accepts(input bit q [$], input bit db);
        if (q.size() < D) return 1'b0;
        foreach (q[k]) if (q[k] == db) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_step();
        int nxt;
        bit pl, pr, s;
        if (rst) begin
            raw_l = '{1'b0, 1'b0};
            raw_r = '{1'b0, 1'b0};
            seen_l.delete();
            seen_r.delete();
            m_db_l = 1'b0;
            m_db_r = 1'b0;
            owner  = 0;
            exp_q.push_back(4'b0000);
            return;
        end
        nxt = owner;
        if (owner == 0) begin
            if (m_db_l && !m_db_r) nxt = 1;
            else if (m_db_r && !m_db_l) nxt = 2;
        end else if (owner == 1 && !m_db_l) begin
            nxt = m_db_r ? 2 : 0;
        end else if (owner == 2 && !m_db_r) begin
            nxt = m_db_l ? 1 : 0;
        end
        pl = (nxt == 1) && (owner != 1);
        pr = (nxt == 2) && (owner != 2);
        owner = nxt;

        s = raw_l.pop_front();
        raw_l.push_back(pin_l);
        seen_l.push_back(s);
        if (seen_l.size() > D) void'(seen_l.pop_front());
        if (accepts(seen_l, m_db_l)) m_db_l = ~m_db_l;

        s = raw_r.pop_front();
        raw_r.push_back(pin_r);
        seen_r.push_back(s);
        if (seen_r.size() > D) void'(seen_r.pop_front());
        if (accepts(seen_r, m_db_r)) m_db_r = ~m_db_r;

        exp_q.push_back({owner == 1, owner == 2, pl, pr});
    endtask

    task automatic cycle(input bit l, input bit r, input bit rs);
        @(negedge clk);
        pin_l = l;
        pin_r = r;
        rst   = rs;
        @(posedge clk);
        model_step();
    endtask

    task automatic hold(input bit l, input bit r, input int n);
        for (int k = 0; k < n; k++) cycle(l, r, 1'b0);
    endtask

    task automatic check(input string name, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        logic [3:0] e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("gpio_left",        out_l,   e[3]);
            check("gpio_right",       out_r,   e[2]);
            check("gpio_left_press",  press_l, e[1]);
            check("gpio_right_press", press_r, e[0]);
        end
    end

    initial begin
        int wait_cnt;
        // Reset with both pins held, then both stay accepted: no direction.
        for (int k = 0; k < 3; k++) cycle(1'b1, 1'b1, 1'b1);
        hold(1, 1, 12);
        hold(0, 0, 12);
        // Single press and release.
        hold(1, 0, 12);
        hold(0, 0, 12);
        // Bounce rejected, then a minimal accepted pulse.
        hold(1, 0, 3);
        hold(0, 0, 1);
        hold(1, 0, 3);
        hold(0, 0, 10);
        hold(1, 0, 4);
        hold(0, 0, 12);
        // Pulse one cycle short of acceptance.
        hold(1, 0, 3);
        hold(0, 0, 10);
        // First-pressed wins, then handover.
        hold(1, 0, 10);
        hold(1, 1, 10);
        hold(0, 1, 12);
        hold(0, 0, 12);
        // Both together, then drop right.
        hold(1, 1, 12);
        hold(1, 0, 12);
        hold(0, 0, 12);
        // Mid-operation reset while left held.
        hold(1, 0, 10);
        cycle(1'b1, 1'b0, 1'b1);
        hold(1, 0, 12);
        hold(0, 0, 12);
        // Random activity, with occasional resets.
        for (int seg = 0; seg < 300; seg++) begin
            bit l, r;
            int n;
            l = 1'($urandom_range(0, 1));
            r = 1'($urandom_range(0, 1));
            n = $urandom_range(1, 10);
            if ($urandom_range(0, 39) == 0) cycle(l, r, 1'b1);
            hold(l, r, n);
        end
        hold(0, 0, 12);

        wait_cnt = 0;
        while (exp_q.size() > 0 && wait_cnt < 10) begin
            @(negedge clk);
            wait_cnt++;
        end
        #1;
        if (exp_q.size() > 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
